muldiv_unit: RTL and testbench

//  Multi-cycle RV32M multiply/divide unit, sitting beside the single-cycle alu in EX.

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// One iteration per cycle on operand magnitudes; sign fix-up applied when the result is latched.
module muldiv_unit #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] in_1_i,
   input  logic [DATA_WIDTH-1:0] in_2_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int unsigned W    = DATA_WIDTH;
   localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e          state_q;
   logic [CntW-1:0] count_q;
   logic [2*W-1:0]  acc_q;
   logic [W-1:0]    b_q;
   logic [2:0]      op_q;
   logic            neg_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [W-1:0]    result_q;

   // Request decode on the raw ports, used only on the accept edge.
   logic            in_is_div;
   logic            in_is_rem;
   logic            in_sgn1;
   logic            in_sgn2;
   logic            in_neg1;
   logic            in_neg2;
   logic [W-1:0]    in_mag1;
   logic [W-1:0]    in_mag2;
   logic            in_div_zero;
   logic            in_div_ovf;
   logic            in_special;
   logic [W-1:0]    in_special_res;
   logic            in_neg_res;
   logic [W-1:0]    most_neg;

   always_comb begin
      most_neg       = {1'b1, {(W-1){1'b0}}};
      in_is_div      = op_i[2];
      in_is_rem      = op_i[2] & op_i[1];
      in_sgn1        = (op_i == 3'b001) || (op_i == 3'b010) ||
                       (op_i == 3'b100) || (op_i == 3'b110);
      in_sgn2        = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
      in_neg1        = in_sgn1 & in_1_i[W-1];
      in_neg2        = in_sgn2 & in_2_i[W-1];
      in_mag1        = in_neg1 ? (~in_1_i + W'(1)) : in_1_i;
      in_mag2        = in_neg2 ? (~in_2_i + W'(1)) : in_2_i;
      in_div_zero    = in_is_div && (in_2_i == '0);
      in_div_ovf     = in_is_div && in_sgn2 && (in_1_i == most_neg) && (in_2_i == '1);
      in_special     = in_div_zero || in_div_ovf;
      if (in_div_zero) begin
         in_special_res = in_is_rem ? in_1_i : '1;
      end else begin
         in_special_res = in_is_rem ? '0 : in_1_i;
      end
      // Remainder follows the dividend sign; product and quotient follow the XOR.
      in_neg_res     = in_is_rem ? in_neg1 : (in_neg1 ^ in_neg2);
   end

   // One radix-2 step of the latched op, plus the sign-corrected result it would produce.
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   logic [W:0]     div_shift;
   logic [W:0]     div_diff;
   logic [2*W-1:0] div_next;
   logic [2*W-1:0] acc_step;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   div_val;
   logic [W-1:0]   div_fix;
   logic [W-1:0]   final_res;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_next  = {mul_sum, acc_q[W-1:1]};
      div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff  = div_shift - {1'b0, b_q};
      if (div_diff[W]) begin
         div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
      end else begin
         div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
      end
      acc_step  = op_q[2] ? div_next : mul_next;
      prod_fix  = neg_q ? (~acc_step + (2*W)'(1)) : acc_step;
      div_val   = op_q[1] ? acc_step[2*W-1:W] : acc_step[W-1:0];
      div_fix   = neg_q ? (~div_val + W'(1)) : div_val;
      if (op_q[2]) begin
         final_res = div_fix;
      end else if (op_q[1:0] == 2'b00) begin
         final_res = prod_fix[W-1:0];
      end else begin
         final_res = prod_fix[2*W-1:W];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q     <= StIdle;
         count_q     <= '0;
         acc_q       <= '0;
         b_q         <= '0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else if (flush_i) begin
         state_q     <= StIdle;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i && in_ready_q) begin
                  op_q       <= op_i;
                  neg_q      <= in_neg_res;
                  count_q    <= '0;
                  in_ready_q <= 1'b0;
                  if (in_special) begin
                     result_q <= in_special_res;
                     state_q  <= StDone;
                  end else begin
                     // Multiply: lo=multiplier, b=multiplicand. Divide: lo=dividend, b=divisor.
                     acc_q   <= {{W{1'b0}}, in_is_div ? in_mag1 : in_mag2};
                     b_q     <= in_is_div ? in_mag2 : in_mag1;
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               acc_q   <= acc_step;
               count_q <= count_q + CntW'(1);
               if (count_q == CntW'(W - 1)) begin
                  result_q <= final_res;
                  state_q  <= StDone;
               end
            end
            StDone: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q     <= StIdle;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latencies, special cases, backpressure, flush, reset.
module tb_muldiv_unit;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] in_1;
   logic [W-1:0] in_2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.DATA_WIDTH(W)) dut (
      .clk_i       (clk),
      .reset_ni    (reset_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .op_i        (op),
      .in_1_i      (in_1),
      .in_2_i      (in_2),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request and return #1 after its accept edge; operands are then scrambled.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("issue_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      op       = o;
      in_1     = a;
      in_2     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op       = 3'($urandom);
      in_1     = $urandom;
      in_2     = $urandom;
   endtask

   task automatic wait_result(input string tag, input int exp_lat, input logic [W-1:0] exp_res);
      int lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, result, exp_res);
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic expect_silence(input string tag, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check({tag, "_no_ov"}, 32'(seen), 32'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      op        = '0;
      in_1      = '0;
      in_2      = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      reset_n = 1'b1;

      issue(3'b000, 32'd7, 32'hFFFF_FFFD);
      check("mul_busy", 32'(in_ready), 32'd0);
      wait_result("mul", 33, 32'hFFFF_FFEB);
      consume("mul");

      issue(3'b001, 32'h8000_0000, 32'h8000_0000);
      wait_result("mulh", 33, 32'h4000_0000);
      consume("mulh");
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_result("mulhu", 33, 32'hFFFF_FFFE);
      consume("mulhu");

      issue(3'b100, 32'hFFFF_FFF9, 32'd2);
      wait_result("div", 33, 32'hFFFF_FFFD);
      consume("div");
      issue(3'b110, 32'hFFFF_FFF9, 32'd2);
      wait_result("rem", 33, 32'hFFFF_FFFF);
      consume("rem");
      issue(3'b101, 32'd100, 32'd7);
      wait_result("divu", 33, 32'd14);
      consume("divu");

      issue(3'b101, 32'd5, 32'd0);
      wait_result("divu_z", 1, 32'hFFFF_FFFF);
      consume("divu_z");
      issue(3'b111, 32'd5, 32'd0);
      wait_result("remu_z", 1, 32'd5);
      consume("remu_z");
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("div_ovf", 1, 32'h8000_0000);
      consume("div_ovf");
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("rem_ovf", 1, 32'd0);
      consume("rem_ovf");

      // MULHSU (-1) x 2 = -2, high half all ones; then hold off the consumer.
      issue(3'b010, 32'hFFFF_FFFF, 32'd2);
      wait_result("mulhsu", 33, 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_result", result, 32'hFFFF_FFFF);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      consume("hold");

      issue(3'b101, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_result", result, 32'd0);
      expect_silence("midrst", 40);

      issue(3'b000, 32'd9, 32'd9);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_in_ready", 32'(in_ready), 32'd1);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      expect_silence("flush", 40);

      // Flush while idle must block a simultaneous request.
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      op       = 3'b000;
      in_1     = 32'd5;
      in_2     = 32'd5;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("idle_flush_ready", 32'(in_ready), 32'd1);
      expect_silence("idle_flush", 40);

      issue(3'b000, 32'd3, 32'd4);
      wait_result("mul_after", 33, 32'd12);
      consume("mul_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
